// File: rtl/btn_conditioner_if.sv
// Signal bundle between board pins and the button conditioner.
// The conditioner takes the slave side; the FSMs or bench take the master side.
interface btn_conditioner_if #(
    parameter int CHANNELS = 5
);
    logic [CHANNELS-1:0] sig_in;
    logic [CHANNELS-1:0] level_out;
    logic [CHANNELS-1:0] rise_out;
    logic [CHANNELS-1:0] fall_out;
    logic [CHANNELS-1:0] repeat_out;

    modport master (
        output sig_in,
        input  level_out,
        input  rise_out,
        input  fall_out,
        input  repeat_out
    );

    modport slave (
        input  sig_in,
        output level_out,
        output rise_out,
        output fall_out,
        output repeat_out
    );
endinterface

// File: rtl/btn_conditioner.sv
// Per-channel synchroniser, debounce counter and edge detector for push-buttons.
// Define BTN_COND_REPEAT_EN to build the hold-to-repeat pulse generator.
module btn_conditioner #(
    parameter int CHANNELS        = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input logic clk,
    input logic rst,
    btn_conditioner_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Repeat timing only matters when the generator is built; zero or negative values are not meaningful.
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_params_out_of_range
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic [CW-1:0]          cnt;
        logic                   lvl;
        logic                   rise;
        logic                   fall;
        logic                   s;
        logic                   accept;

        assign s      = sync[SYNC_STAGES-1];
        assign accept = (s != lvl) && (cnt == CNT_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync <= '0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], bus.sig_in[i]};
            end
        end

        // Any sample agreeing with the stable level restarts the count, which is what rejects glitches.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt  <= '0;
                lvl  <= 1'b0;
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                if (s == lvl) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    lvl  <= s;
                    cnt  <= '0;
                    rise <= s;
                    fall <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign bus.level_out[i] = lvl;
        assign bus.rise_out[i]  = rise;
        assign bus.fall_out[i]  = fall;

`ifdef BTN_COND_REPEAT_EN
        localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int TW      = $clog2(TMR_MAX + 1);

        logic [TW-1:0] tmr;
        logic          rep;

        // Down-counter: loaded on the accepted press, reloaded with the period after each pulse.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tmr <= '0;
                rep <= 1'b0;
            end else begin
                rep <= 1'b0;
                if (accept && s) begin
                    tmr <= TW'(REPEAT_DELAY - 1);
                end else if (accept || !lvl) begin
                    tmr <= '0;
                end else if (tmr == '0) begin
                    rep <= 1'b1;
                    tmr <= TW'(REPEAT_PERIOD - 1);
                end else begin
                    tmr <= tmr - 1'b1;
                end
            end
        end

        assign bus.repeat_out[i] = rep;
`else
        assign bus.repeat_out[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: per-scenario tasks push expected output vectors
// for each cycle into a queue, then pop and compare as the cycles run.
module tb_btn_conditioner;
    localparam int CH  = 2;
    localparam int SS  = 2;
    localparam int DC  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = SS + DC;
    localparam int W   = 4 * CH;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    btn_conditioner_if #(.CHANNELS(CH)) bus ();

    btn_conditioner #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs;

    // ---------------- helpers (stimulus only) ----------------
    function automatic logic [W-1:0] pack(input logic [CH-1:0] l, input logic [CH-1:0] r,
                                          input logic [CH-1:0] f, input logic [CH-1:0] p);
        return {p, f, r, l};
    endfunction

    // Called at a falling edge: drive, let one rising edge pass, sample, return at next falling edge.
    task automatic step(input logic [CH-1:0] v);
        bus.sig_in = v;
        @(posedge clk);
        #1;
        obs = {bus.repeat_out, bus.fall_out, bus.rise_out, bus.level_out};
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [CH-1:0] v);
        bus.sig_in = v;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [W-1:0] e;
        logic [W-1:0] now;
        rst = 1'b0;
        bus.sig_in = 2'b11;
        #1 rst = 1'b1;
        #1;
        now = {bus.repeat_out, bus.fall_out, bus.rise_out, bus.level_out};
        tests_run++;
        if (now !== '0) begin
            tests_failed++;
            $display("FAIL reset_assert: got %b expected %b", now, {W{1'b0}});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++)
            exp_q.push_back(pack((c >= LAT) ? 2'b11 : 2'b00, (c == LAT) ? 2'b11 : 2'b00, 2'b00, 2'b00));
        for (int c = 1; c <= 8; c++) begin
            step(2'b11);
            e = exp_q.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL reset_release cycle %0d: got %b expected %b", c, obs, e);
            end
        end
        // Level is now 11; assert reset between edges and expect immediate clearing.
        #2 rst = 1'b1;
        #1;
        now = {bus.repeat_out, bus.fall_out, bus.rise_out, bus.level_out};
        tests_run++;
        if (now !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: got %b expected %b", now, {W{1'b0}});
        end
        @(negedge clk);
    endtask

    task automatic test_press();
        logic [W-1:0] e;
        do_reset(2'b00);
        for (int c = 1; c <= 9; c++)
            exp_q.push_back(pack({1'b0, c >= LAT}, {1'b0, c == LAT}, 2'b00, 2'b00));
        for (int c = 1; c <= 9; c++) begin
            step(2'b01);
            e = exp_q.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL press cycle %0d: got %b expected %b", c, obs, e);
            end
        end
    endtask

    // Continues from test_press with ch0 held; fall lands one edge before the first repeat would be due.
    task automatic test_release();
        logic [W-1:0] e;
        for (int c = 1; c <= 9; c++)
            exp_q.push_back(pack({1'b0, c < LAT}, 2'b00, {1'b0, c == LAT}, 2'b00));
        for (int c = 1; c <= 9; c++) begin
            step(2'b00);
            e = exp_q.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL release cycle %0d: got %b expected %b", c, obs, e);
            end
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] e;
        logic         v;
        localparam int FINAL_CAP = 5;
        localparam int RISE_AT   = FINAL_CAP + LAT - 1;
        do_reset(2'b00);
        for (int c = 1; c <= 13; c++)
            exp_q.push_back(pack({1'b0, c >= RISE_AT}, {1'b0, c == RISE_AT}, 2'b00, 2'b00));
        for (int c = 1; c <= 13; c++) begin
            v = (c != 4);
            step({1'b0, v});
            e = exp_q.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL bounce cycle %0d: got %b expected %b", c, obs, e);
            end
        end
    endtask

    task automatic test_repeat();
        localparam int N      = 30;
        localparam int E      = LAT;
        localparam int FALL_AT = E + 19;
        localparam int REL_CAP = FALL_AT - LAT + 1;
        logic [W-1:0] e;
        logic         noise[1:N];
        logic         l1, r1, f1, p1;
        int           c;
        int           hi;
        int           lo;
        c = 1;
        while (c <= N) begin
            hi = $urandom_range(1, DC - 1);
            lo = $urandom_range(1, 3);
            for (int k = 0; k < hi && c <= N; k++) begin noise[c] = 1'b1; c++; end
            for (int k = 0; k < lo && c <= N; k++) begin noise[c] = 1'b0; c++; end
        end
        do_reset(2'b00);
        for (int t = 1; t <= N; t++) begin
            l1 = (t >= E) && (t < FALL_AT);
            r1 = (t == E);
            f1 = (t == FALL_AT);
`ifdef BTN_COND_REPEAT_EN
            p1 = (t >= E + RD) && (t < FALL_AT) && (((t - E - RD) % RP) == 0);
`else
            p1 = 1'b0;
`endif
            exp_q.push_back(pack({l1, 1'b0}, {r1, 1'b0}, {f1, 1'b0}, {p1, 1'b0}));
        end
        for (int t = 1; t <= N; t++) begin
            step({(t < REL_CAP) ? 1'b1 : 1'b0, noise[t]});
            e = exp_q.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL repeat cycle %0d: got %b expected %b", t, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] e;
        logic [W-1:0] now;
        do_reset(2'b00);
        for (int c = 1; c <= 4; c++) exp_q.push_back('0);
        for (int c = 1; c <= 4; c++) begin
            step(2'b01);
            e = exp_q.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL midreset_pre cycle %0d: got %b expected %b", c, obs, e);
            end
        end
        // Count is at 2 here; abort it with the input still high.
        rst = 1'b1;
        #1;
        now = {bus.repeat_out, bus.fall_out, bus.rise_out, bus.level_out};
        tests_run++;
        if (now !== '0) begin
            tests_failed++;
            $display("FAIL midreset_assert: got %b expected %b", now, {W{1'b0}});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 9; c++)
            exp_q.push_back(pack({1'b0, c >= LAT}, {1'b0, c == LAT}, 2'b00, 2'b00));
        for (int c = 1; c <= 9; c++) begin
            step(2'b01);
            e = exp_q.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL midreset_post cycle %0d: got %b expected %b", c, obs, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_repeat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Multi-channel input conditioner for the alarm clock's push-buttons and switches. Each channel passes through a parametrised flip-flop synchroniser, a per-channel debounce counter and an edge detector, producing a clean level plus single-cycle press and release pulses. An optional compiled-in auto-repeat generator emits periodic pulses while a button is held, for fast time and alarm setting. It sits between the board pins and the mode/setting FSMs and replaces bare two-stage synchronisers on all asynchronous inputs.

## Interface
Parameters:
- CHANNELS, 5: number of independent input channels.
- SYNC_STAGES, 2: synchroniser depth; legal range ≥ 2.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a change; legal range ≥ 1.
- REPEAT_DELAY, 64: cycles from accepted press to first repeat pulse; used only with repeat compiled in.
- REPEAT_PERIOD, 16: cycles between subsequent repeat pulses; used only with repeat compiled in.

Ports:
- clk  in  1  single system clock; all flops rise-edge.
- rst  in  1  asynchronous, active-high reset.
- sig_in  in  CHANNELS  raw asynchronous inputs; bit i is channel i.
- level_out  out  CHANNELS  debounced level.
- rise_out  out  CHANNELS  one-cycle pulse on accepted 0→1.
- fall_out  out  CHANNELS  one-cycle pulse on accepted 1→0.
- repeat_out  out  CHANNELS  auto-repeat pulses; constant 0 when repeat is compiled out.

## Operation
- Channels are fully independent, with no shared state.
- Synchroniser: a SYNC_STAGES-deep shift chain per channel; the last stage is s.
- Debounce state per channel: stable level L (drives level_out) and counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
  - If s == L, cnt ← 0.
  - If s != L and cnt == DEBOUNCE_CYCLES-1: L ← s, cnt ← 0.
  - Otherwise cnt ← cnt+1.
- rise_out and fall_out are registered and update on the same edge as L.
  - rise_out is 1 for exactly one cycle when L goes 0→1.
  - fall_out is 1 for exactly one cycle when L goes 1→0.
  - Both are never high in the same cycle.
- Glitch rejection: any s excursion shorter than DEBOUNCE_CYCLES cycles leaves L unchanged and restarts cnt from 0.

## Timing
- Reset: all synchroniser stages, L, cnt, repeat timers and every output are cleared to 0 asynchronously.
- Latency: a sig_in change first captured at edge 1 appears on level_out/rise_out/fall_out after edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults this is 18 edges.
- Input held high across reset release: treated as a new press, so rise_out fires SYNC_STAGES+DEBOUNCE_CYCLES edges after release.
- Reset asserted mid-count or mid-repeat aborts the operation; no pulse is emitted.
- With DEBOUNCE_CYCLES = 1, L follows s with a one-cycle delay.

## Configuration
- Macro BTN_COND_REPEAT_EN.
- Defined: each channel has a repeat timer of width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
  - If rise_out pulses at edge E, repeat_out pulses at edges E+REPEAT_DELAY, then E+REPEAT_DELAY+k·REPEAT_PERIOD for k ≥ 1, while L stays 1.
  - When L falls, the timer clears. A repeat pulse due on the same edge as the fall is suppressed.
  - repeat_out never coincides with rise_out.
- Undefined: no timer logic is built and repeat_out is tied to 0.

## Test plan
Bench parameters: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: assert rst with sig_in=2'b11 → all outputs 0 immediately. Release rst → level_out[1:0]=11 and a rise_out pulse at edge 6 after release.
- Clean press on ch0: sig_in[0] 0→1 captured at edge 1 → level_out[0]=1 and rise_out[0]=1 for one cycle at edge 6. ch1 outputs stay 0.
- Bounce: sig_in[0] high for 3 cycles, low for 1, then high steadily → no rise during the bounce; rise_out[0] occurs 6 edges after the final rising capture.
- Release: after a press, sig_in[0] 1→0 → fall_out[0] one-cycle pulse and level_out[0]=0 at edge 6. rise_out is never high at the same time.
- Repeat (macro defined): hold ch1 with rise_out at edge E → repeat_out[1] at E+10, E+13, E+16. Release so L falls at E+19 → no pulse at E+19 or later. With the macro undefined, repeat_out stays 0 throughout.
- Reset mid-debounce: assert rst when cnt=2 → no rise_out is emitted, and level_out stays 0 until a full 6-edge acceptance after release.
